// File: rtl/ripple_add_sequencer.sv
// Multi-precision adder: one shared 4-bit ripple-carry slice, one slice per clock, LSB first.
// Optional signed-overflow output enabled by defining RCA_SEQ_OVF_EN.
module ripple_add_sequencer #(
    parameter int unsigned SLICE_W    = 4,
    parameter int unsigned NUM_SLICES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SLICE_W*NUM_SLICES-1:0] op_a,
    input  logic [SLICE_W*NUM_SLICES-1:0] op_b,
    input  logic                          op_cin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SLICE_W*NUM_SLICES-1:0] sum,
    output logic                          cout,
    output logic                          busy
`ifdef RCA_SEQ_OVF_EN
    ,
    output logic                          ovf
`endif
);

    localparam int unsigned W    = SLICE_W * NUM_SLICES;
    localparam int unsigned IdxW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      sum_q, sum_d;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic [SLICE_W:0]   slice_c;
    logic               last_slice;

    assign last_slice = (idx_q == IdxW'(NUM_SLICES - 1));

    // Shared ripple-carry slice; its carry-in comes only from the carry register.
    always_comb begin
        slice_a   = '0;
        slice_b   = '0;
        slice_sum = '0;
        slice_c   = '0;
        for (int s = 0; s < int'(NUM_SLICES); s++) begin
            if (idx_q == IdxW'(s)) begin
                slice_a = a_q[s*SLICE_W +: SLICE_W];
                slice_b = b_q[s*SLICE_W +: SLICE_W];
            end
        end
        slice_c[0] = carry_q;
        for (int i = 0; i < int'(SLICE_W); i++) begin
            slice_sum[i]   = slice_a[i] ^ slice_b[i] ^ slice_c[i];
            slice_c[i+1]   = (slice_a[i] & slice_b[i]) | (slice_c[i] & (slice_a[i] ^ slice_b[i]));
        end
    end

`ifdef RCA_SEQ_OVF_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
`ifdef RCA_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    carry_d = op_cin;
                    sum_d   = '0;
                    idx_d   = '0;
`ifdef RCA_SEQ_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = StRun;
                end
            end
            StRun: begin
                for (int s = 0; s < int'(NUM_SLICES); s++) begin
                    if (idx_q == IdxW'(s)) begin
                        sum_d[s*SLICE_W +: SLICE_W] = slice_sum;
                    end
                end
                carry_d = slice_c[SLICE_W];
                if (last_slice) begin
`ifdef RCA_SEQ_OVF_EN
                    // Carry into the MSB differs from carry out of it: signed overflow.
                    ovf_d = slice_c[SLICE_W-1] ^ slice_c[SLICE_W];
`endif
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

`ifdef RCA_SEQ_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q & out_valid;
`endif

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign sum       = sum_q;
    assign cout      = carry_q & out_valid;

endmodule

// File: tb/tb_ripple_add_sequencer.sv
// Self-checking bench for ripple_add_sequencer: vector table, scoreboard, handshake corner cases.
// Define RCA_SEQ_OVF_EN to also check the overflow output.
module tb_ripple_add_sequencer;

    localparam int NS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic        op_cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        cout;
    logic        busy;
`ifdef RCA_SEQ_OVF_EN
    logic        ovf;
`endif

    ripple_add_sequencer #(
        .SLICE_W    (4),
        .NUM_SLICES (NS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_cin    (op_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef RCA_SEQ_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        exp_t        exp;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic cin);
        exp_t       e;
        logic [16:0] r;
        r      = 17'(a) + 17'(b) + 17'(cin);
        e.sum  = r[15:0];
        e.cout = r[16];
        e.ovf  = (a[15] == b[15]) && (r[15] != a[15]);
        return e;
    endfunction

    task automatic compare_pop(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL %s_sb: result 0x%0h with no expected entry", tag, sum);
        end else begin
            e = sb.pop_front();
            check({tag, "_sum"}, 32'(sum), 32'(e.sum));
            check({tag, "_cout"}, 32'(cout), 32'(e.cout));
`ifdef RCA_SEQ_OVF_EN
            check({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
`endif
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input exp_t e, input bit push);
        op_a = a; op_b = b; op_cin = cin; in_valid = 1'b1;
        for (int k = 0; k < 30 && !in_ready; k++) begin
            @(posedge clk); #1;
        end
        check("in_ready", 32'(in_ready), 32'd1);
        if (push) sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic recv(input string tag, output int waits);
        out_ready = 1'b1;
        waits = 0;
        while (!out_valid && waits < 30) begin
            @(posedge clk); #1;
            waits++;
        end
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        compare_pop(tag);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_drop"}, 32'(out_valid), 32'd0);
    endtask

    vec_t vecs[10];

    initial begin
        int   waits;
        int   last;
        exp_t e;
        logic [15:0] ra, rb;
        logic        rc;

        vecs[0] = '{16'h1234, 16'h4321, 1'b1, '{16'h5556, 1'b0, 1'b0}};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0}};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1}};
        vecs[3] = '{16'h00A5, 16'h005A, 1'b0, '{16'h00FF, 1'b0, 1'b0}};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, '{16'h0000, 1'b1, 1'b1}};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, '{16'hFFFF, 1'b1, 1'b0}};
        vecs[6] = '{16'h0F0F, 16'hF0F0, 1'b1, '{16'h0000, 1'b1, 1'b0}};
        vecs[7] = '{16'h0000, 16'h0000, 1'b0, '{16'h0000, 1'b0, 1'b0}};
        vecs[8] = '{16'hABCD, 16'h1234, 1'b0, '{16'hBE01, 1'b0, 1'b0}};
        vecs[9] = '{16'h4000, 16'h4000, 1'b0, '{16'h8000, 1'b0, 1'b1}};

        // Reset state
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Vector table, with latency and captured-operand immunity
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp, 1'b1);
            op_a = ~vecs[i].a;
            op_b = 16'h5A5A;
            check("run_busy", 32'(busy), 32'd1);
            recv("vec", waits);
            check("latency", 32'(waits), 32'(NS));
        end

        // Random operands against the arithmetic model
        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            send(ra, rb, rc, model(ra, rb, rc), 1'b1);
            recv("rand", waits);
        end

        // Hold result in DONE for 10 cycles with a second request pending
        send(16'h1234, 16'h4321, 1'b1, model(16'h1234, 16'h4321, 1'b1), 1'b1);
        for (int k = 0; k < 30 && !out_valid; k++) begin
            @(posedge clk); #1;
        end
        check("hold_out_valid", 32'(out_valid), 32'd1);
        op_a = 16'h00A5; op_b = 16'h005A; op_cin = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            check("hold_sum", 32'(sum), 32'h5556);
            check("hold_cout", 32'(cout), 32'd0);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        check("hold_release_in_ready", 32'(in_ready), 32'd0);
        compare_pop("hold");
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("pend_out_valid", 32'(out_valid), 32'd0);
        check("pend_in_ready", 32'(in_ready), 32'd1);
        sb.push_back(model(16'h00A5, 16'h005A, 1'b0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pend_accepted", 32'(busy), 32'd1);
        recv("pend", waits);

        // Reset asserted in the second RUN cycle
        send(16'hFFFF, 16'h0001, 1'b0, e, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
`ifdef RCA_SEQ_OVF_EN
        check("abort_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check("abort_no_valid", 32'(out_valid), 32'd0);
        end
        send(16'h00A5, 16'h005A, 1'b0, model(16'h00A5, 16'h005A, 1'b0), 1'b1);
        recv("after_abort", waits);

        // Back-to-back with out_ready held high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
        op_a = ra; op_b = rb; op_cin = rc;
        last = -1;
        for (int i = 0; i < 40; i++) begin
            bit hs;
            if (out_valid) begin
                compare_pop("b2b");
                if (last >= 0) check("b2b_period", 32'(i - last), 32'(NS + 2));
                last = i;
            end
            hs = in_ready;
            if (hs) sb.push_back(model(ra, rb, rc));
            @(posedge clk); #1;
            if (hs) begin
                ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
                op_a = ra; op_b = rb; op_cin = rc;
            end
        end
        in_valid = 1'b0;
        for (int k = 0; k < 30 && sb.size() != 0; k++) begin
            if (out_valid) compare_pop("b2b_drain");
            @(posedge clk); #1;
        end
        check("sb_drained", 32'(sb.size()), 32'd0);
        out_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
